// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC LVDS frame-alignment path.
// Holds the alignment FSM state enum, the deserializer width and default frame word.
package adc_pkg;

  localparam int DESER_WIDTH = 8;

  localparam logic [DESER_WIDTH-1:0] FRAME_PATTERN_DEF = 8'hF0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CHECK   = 3'd2,
    SLIP    = 3'd3,
    CONFIRM = 3'd4,
    LOCKED  = 3'd5,
    FAIL    = 3'd6
  } align_state_t;

endpackage

// File: rtl/adc_align_ctrl.sv
// Frame-alignment sequencer: issues spaced bitslip pulses until the frame word
// matches, confirms lock, watches for loss of lock and re-aligns.
// Ports: CLKDIV (clock), cpu_resetn (sync active-low), en, frm_data[7:0] in;
// bitslip, aligned, align_err, lock_lost, slip_cnt[3:0], relock_cnt[7:0],
// state_o[2:0] out (all registered).
module adc_align_ctrl
  import adc_pkg::*;
#(
  parameter logic [DESER_WIDTH-1:0] FRAME_PATTERN = FRAME_PATTERN_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_SLIPS     = 8,
  parameter int CONFIRM_CNT   = 8,
  parameter int LOSS_THRESH   = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                   CLKDIV,
  input  logic                   cpu_resetn,
  input  logic                   en,
  input  logic [DESER_WIDTH-1:0] frm_data,
  output logic                   bitslip,
  output logic                   aligned,
  output logic                   align_err,
  output logic                   lock_lost,
  output logic [3:0]             slip_cnt,
  output logic [7:0]             relock_cnt,
  output logic [2:0]             state_o
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int MW = $clog2(CONFIRM_CNT + 1);
  localparam int LW = $clog2(LOSS_THRESH + 1);

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    SLIP_MAX    = 4'(MAX_SLIPS);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
  localparam logic [MW-1:0] CONF_MAX    = MW'(CONFIRM_CNT);
  localparam logic [LW-1:0] LOSS_MAX    = LW'(LOSS_THRESH);

  align_state_t    state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [3:0]      slip_q, slip_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [MW-1:0]   match_q, match_d;
  logic [LW-1:0]   miss_q, miss_d;
  logic [7:0]      relock_q, relock_d;
  logic            bitslip_q, bitslip_d;
  logic            aligned_q, aligned_d;
  logic            err_q, err_d;
  logic            lost_q, lost_d;

  logic            hit;

  assign hit = (frm_data == FRAME_PATTERN);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    retry_d  = retry_q;
    match_d  = match_q;
    miss_d   = miss_q;
    relock_d = relock_q;
    lost_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        slip_d  = '0;
        retry_d = '0;
        match_d = '0;
        miss_d  = '0;
        if (en) begin
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        if (settle_q == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end

      CHECK, CONFIRM: begin
        if (hit) begin
          if (state_q == CHECK) begin
            match_d = MW'(1);
            state_d = CONFIRM;
          end else begin
            match_d = match_q + 1'b1;
            if (match_d == CONF_MAX) begin
              state_d = LOCKED;
            end
          end
        end else begin
          // Mismatch: slip again, start a new sweep, or give up.
          match_d = '0;
          if (slip_q < SLIP_MAX) begin
            state_d = SLIP;
          end else if (retry_q < RETRY_MAX) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
            retry_d  = retry_q + 1'b1;
            slip_d   = '0;
          end else begin
            state_d = FAIL;
          end
        end
      end

      SLIP: begin
        slip_d   = slip_q + 1'b1;
        state_d  = SETTLE;
        settle_d = SETTLE_LOAD;
      end

      LOCKED: begin
        if (hit) begin
          miss_d = '0;
        end else if (miss_q + 1'b1 == LOSS_MAX) begin
          lost_d   = 1'b1;
          if (relock_q != 8'hFF) begin
            relock_d = relock_q + 1'b1;
          end
          slip_d   = '0;
          retry_d  = '0;
          match_d  = '0;
          miss_d   = '0;
          state_d  = SETTLE;
          settle_d = SETTLE_LOAD;
        end else begin
          miss_d = miss_q + 1'b1;
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Dropping enable wins over everything; loss history survives.
    if (!en) begin
      state_d  = IDLE;
      settle_d = '0;
      slip_d   = '0;
      retry_d  = '0;
      match_d  = '0;
      miss_d   = '0;
      lost_d   = 1'b0;
    end

    bitslip_d = (state_d == SLIP);
    aligned_d = (state_d == LOCKED);
    err_d     = (state_d == FAIL);
  end

  always_ff @(posedge CLKDIV) begin
    if (!cpu_resetn) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      slip_q    <= '0;
      retry_q   <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      relock_q  <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      slip_q    <= slip_d;
      retry_q   <= retry_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      relock_q  <= relock_d;
      bitslip_q <= bitslip_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
    end
  end

  assign bitslip    = bitslip_q;
  assign aligned    = aligned_q;
  assign align_err  = err_q;
  assign lock_lost  = lost_q;
  assign slip_cnt   = slip_q;
  assign relock_cnt = relock_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Directed self-checking bench for adc_align_ctrl.
// Models a deserializer whose word rotates left by one bit per bitslip.
module tb_adc_align_ctrl;

  logic       CLKDIV;
  logic       cpu_resetn;
  logic       en;
  logic [7:0] frm;
  logic       bitslip;
  logic       aligned;
  logic       align_err;
  logic       lock_lost;
  logic [3:0] slip_cnt;
  logic [7:0] relock_cnt;
  logic [2:0] state_o;

  int pass;
  int total;
  int cyc;
  logic rot;

  adc_align_ctrl dut (
    .CLKDIV     (CLKDIV),
    .cpu_resetn (cpu_resetn),
    .en         (en),
    .frm_data   (frm),
    .bitslip    (bitslip),
    .aligned    (aligned),
    .align_err  (align_err),
    .lock_lost  (lock_lost),
    .slip_cnt   (slip_cnt),
    .relock_cnt (relock_cnt),
    .state_o    (state_o)
  );

  initial CLKDIV = 1'b0;
  always #5 CLKDIV = ~CLKDIV;

  task automatic tick();
    @(posedge CLKDIV);
    #1;
    cyc++;
    if (rot && bitslip) frm = {frm[6:0], frm[7]};
  endtask

  task automatic test_reset();
    cpu_resetn = 1'b0;
    en = 1'b0;
    frm = 8'h00;
    rot = 1'b0;
    repeat (3) tick();
    total++;
    if (state_o !== 3'd0) $display("FAIL rst_state got %0d exp 0", state_o);
    else pass++;
    total++;
    if ({bitslip, aligned, align_err, lock_lost} !== 4'b0)
      $display("FAIL rst_flags got %b exp 0000",
               {bitslip, aligned, align_err, lock_lost});
    else pass++;
    total++;
    if ({slip_cnt, relock_cnt} !== 12'h0)
      $display("FAIL rst_cnts got %h exp 000", {slip_cnt, relock_cnt});
    else pass++;
    cpu_resetn = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    logic seen;
    seen = 1'b0;
    frm = 8'hF0;
    en = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (bitslip) seen = 1'b1;
      if (c == 12) begin
        total++;
        if (aligned !== 1'b0) $display("FAIL lat_early got %b exp 0", aligned);
        else pass++;
      end
    end
    total++;
    if (aligned !== 1'b1) $display("FAIL lat_13 got %b exp 1", aligned);
    else pass++;
    total++;
    if (state_o !== 3'd5) $display("FAIL lat_state got %0d exp 5", state_o);
    else pass++;
    total++;
    if (slip_cnt !== 4'd0) $display("FAIL lat_slips got %0d exp 0", slip_cnt);
    else pass++;
    total++;
    if (seen !== 1'b0) $display("FAIL lat_noslip got %b exp 0", seen);
    else pass++;
    en = 1'b0;
    tick();
    total++;
    if ({state_o, aligned} !== 4'b0) $display("FAIL lat_off got %b exp 0000", {state_o, aligned});
    else pass++;
  endtask

  task automatic test_rotate();
    int n;
    int last;
    int gap;
    n = 0;
    last = -1;
    gap = 1000;
    frm = 8'h1E;
    rot = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 200 && !aligned; i++) begin
      tick();
      if (bitslip) begin
        n++;
        if (last >= 0 && cyc - last < gap) gap = cyc - last;
        last = cyc;
      end
    end
    rot = 1'b0;
    total++;
    if (aligned !== 1'b1) $display("FAIL rot_lock got %b exp 1", aligned);
    else pass++;
    total++;
    if (n != 3) $display("FAIL rot_pulses got %0d exp 3", n);
    else pass++;
    total++;
    if (gap < 5) $display("FAIL rot_gap got %0d exp >=5", gap);
    else pass++;
    total++;
    if (slip_cnt !== 4'd3) $display("FAIL rot_slipcnt got %0d exp 3", slip_cnt);
    else pass++;
  endtask

  task automatic test_loss();
    logic bad;
    bad = 1'b0;
    frm = 8'hAA;
    repeat (3) begin
      tick();
      if (!aligned || lock_lost) bad = 1'b1;
    end
    frm = 8'hF0;
    tick();
    if (!aligned || lock_lost) bad = 1'b1;
    frm = 8'hAA;
    repeat (3) begin
      tick();
      if (!aligned || lock_lost) bad = 1'b1;
    end
    frm = 8'hF0;
    tick();
    if (!aligned || lock_lost) bad = 1'b1;
    total++;
    if (bad !== 1'b0) $display("FAIL loss_hold got %b exp 0", bad);
    else pass++;
    frm = 8'hAA;
    repeat (3) tick();
    total++;
    if (aligned !== 1'b1) $display("FAIL loss_3rd got %b exp 1", aligned);
    else pass++;
    tick();
    total++;
    if ({lock_lost, aligned} !== 2'b10)
      $display("FAIL loss_pulse got %b exp 10", {lock_lost, aligned});
    else pass++;
    total++;
    if (relock_cnt !== 8'd1) $display("FAIL loss_relock got %0d exp 1", relock_cnt);
    else pass++;
    total++;
    if ({state_o, slip_cnt} !== {3'd1, 4'd0})
      $display("FAIL loss_resweep got %0d/%0d exp 1/0", state_o, slip_cnt);
    else pass++;
    frm = 8'hF0;
    tick();
    total++;
    if (lock_lost !== 1'b0) $display("FAIL loss_onecyc got %b exp 0", lock_lost);
    else pass++;
    for (int i = 0; i < 40 && !aligned; i++) tick();
    total++;
    if (aligned !== 1'b1) $display("FAIL loss_relock_wait got %b exp 1", aligned);
    else pass++;
  endtask

  task automatic test_fail();
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    en = 1'b0;
    tick();
    frm = 8'hAA;
    en = 1'b1;
    for (int i = 0; i < 2000 && !align_err; i++) begin
      tick();
      if (bitslip) n++;
    end
    total++;
    if (align_err !== 1'b1) $display("FAIL fail_err got %b exp 1", align_err);
    else pass++;
    total++;
    if (n != 32) $display("FAIL fail_pulses got %0d exp 32", n);
    else pass++;
    total++;
    if ({state_o, slip_cnt} !== {3'd6, 4'd8})
      $display("FAIL fail_state got %0d/%0d exp 6/8", state_o, slip_cnt);
    else pass++;
    repeat (20) begin
      tick();
      if (!align_err || bitslip || state_o != 3'd6) bad = 1'b1;
    end
    total++;
    if (bad !== 1'b0) $display("FAIL fail_hold got %b exp 0", bad);
    else pass++;
    en = 1'b0;
    tick();
    total++;
    if ({state_o, align_err, slip_cnt} !== 8'h0)
      $display("FAIL fail_exit got %h exp 00", {state_o, align_err, slip_cnt});
    else pass++;
    total++;
    if (relock_cnt !== 8'd1) $display("FAIL fail_relock got %0d exp 1", relock_cnt);
    else pass++;
  endtask

  task automatic test_en_drop_slip();
    frm = 8'hAA;
    en = 1'b1;
    for (int i = 0; i < 50 && !bitslip; i++) tick();
    total++;
    if ({bitslip, state_o} !== 4'b1011)
      $display("FAIL drop_inslip got %b exp 1011", {bitslip, state_o});
    else pass++;
    en = 1'b0;
    tick();
    total++;
    if ({state_o, bitslip, aligned, align_err, lock_lost, slip_cnt} !== 11'h0)
      $display("FAIL drop_out got %h exp 000",
               {state_o, bitslip, aligned, align_err, lock_lost, slip_cnt});
    else pass++;
    total++;
    if (relock_cnt !== 8'd1) $display("FAIL drop_relock got %0d exp 1", relock_cnt);
    else pass++;
  endtask

  task automatic test_reset_confirm();
    frm = 8'hF0;
    en = 1'b1;
    for (int i = 0; i < 30 && state_o != 3'd4; i++) tick();
    total++;
    if (state_o !== 3'd4) $display("FAIL rstc_confirm got %0d exp 4", state_o);
    else pass++;
    cpu_resetn = 1'b0;
    tick();
    total++;
    if ({state_o, bitslip, aligned, align_err, lock_lost, slip_cnt} !== 11'h0)
      $display("FAIL rstc_out got %h exp 000",
               {state_o, bitslip, aligned, align_err, lock_lost, slip_cnt});
    else pass++;
    total++;
    if (relock_cnt !== 8'd0) $display("FAIL rstc_relock got %0d exp 0", relock_cnt);
    else pass++;
    cpu_resetn = 1'b1;
    en = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    logic to;
    to = 1'b0;
    frm = 8'hF0;
    en = 1'b1;
    for (int k = 0; k < 256 && !to; k++) begin
      for (int i = 0; i < 40 && !aligned; i++) tick();
      if (!aligned) to = 1'b1;
      frm = 8'hAA;
      repeat (4) tick();
      frm = 8'hF0;
      if (k == 254) begin
        total++;
        if (relock_cnt !== 8'd255) $display("FAIL sat_255 got %0d exp 255", relock_cnt);
        else pass++;
      end
    end
    total++;
    if (to !== 1'b0) $display("FAIL sat_timeout got %b exp 0", to);
    else pass++;
    total++;
    if (relock_cnt !== 8'd255) $display("FAIL sat_hold got %0d exp 255", relock_cnt);
    else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    cyc = 0;
    test_reset();
    test_aligned();
    test_rotate();
    test_loss();
    test_fail();
    test_en_drop_slip();
    test_reset_confirm();
    test_saturate();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
